// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stall/flush enables,
// E-stage operand forwarding and a saturating stall-cycle counter.

module pipeline_hazard_fwd #(
   parameter int REG_ADDR = 5
) (
   input  logic [REG_ADDR-1:0] rs,
   input  logic [REG_ADDR-1:0] rdm,
   input  logic                regwritem,
   input  logic [REG_ADDR-1:0] rdw,
   input  logic                regwritew,
   output logic [1:0]          fwd
);
   // x0 is never a real producer, so a match on it must not forward.
   always_comb begin
      fwd = 2'b00;
      if (regwritem && rdm != '0 && rdm == rs)
         fwd = 2'b10;
      else if (regwritew && rdw != '0 && rdw == rs)
         fwd = 2'b01;
   end
endmodule

module pipeline_hazard_ctrl #(
   parameter int CNT_WIDTH = 32,
   parameter int REG_ADDR  = 5
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [REG_ADDR-1:0]  Rs1D,
   input  logic [REG_ADDR-1:0]  Rs2D,
   input  logic [REG_ADDR-1:0]  Rs1E,
   input  logic [REG_ADDR-1:0]  Rs2E,
   input  logic [REG_ADDR-1:0]  RdE,
   input  logic                 LoadE,
   input  logic [REG_ADDR-1:0]  RdM,
   input  logic                 RegWriteM,
   input  logic [REG_ADDR-1:0]  RdW,
   input  logic                 RegWriteW,
   input  logic                 PCSrcE,
   input  logic                 MemReqM,
   input  logic                 MemReadyM,
   output logic                 StallF,
   output logic                 StallD,
   output logic                 StallE,
   output logic                 StallM,
   output logic                 FlushD,
   output logic                 FlushE,
   output logic [1:0]           ForwardAE,
   output logic [1:0]           ForwardBE,
   output logic [CNT_WIDTH-1:0] StallCount
);
   typedef enum logic [1:0] {INIT, RUN, MEMWAIT} state_t;
   state_t state;

   logic memwait, loaduse;

   // Once waiting, only MemReadyM releases us; MemReqM may already have moved on.
   assign memwait = (state == MEMWAIT) ? ~MemReadyM
                                       : (state == RUN) && MemReqM && ~MemReadyM;
   assign loaduse = LoadE && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);

   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      if (state == INIT) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (memwait) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
      end else if (PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (loaduse) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= INIT;
         StallCount <= '0;
      end else begin
         state <= memwait ? MEMWAIT : RUN;
         if (StallF && !(&StallCount))
            StallCount <= StallCount + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   logic [1:0][REG_ADDR-1:0] rs_e;
   logic [1:0][1:0]          fwd;
   assign rs_e      = {Rs2E, Rs1E};
   assign ForwardAE = fwd[0];
   assign ForwardBE = fwd[1];

   for (genvar g = 0; g < 2; g++) begin : g_fwd
      pipeline_hazard_fwd #(.REG_ADDR(REG_ADDR)) u_fwd (
         .rs        (rs_e[g]),
         .rdm       (RdM),
         .regwritem (RegWriteM),
         .rdw       (RdW),
         .regwritew (RegWriteW),
         .fwd       (fwd[g])
      );
   end
endmodule
